comp_gt8_rr_sched: RTL



---
 rtl/comp_gt8_rr_sched.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/comp_gt8_rr_sched.sv
// Round-robin scheduler that time-shares one comp_gt8 (unsigned a > b) among N_REQ requesters.
// Optional COMP_GT8_RR_SCHED_STATS_EN adds saturating compare / greater-than counters.

module comp_gt8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       gt
);
  assign gt = (a > b);
endmodule

module comp_gt8_rr_sched #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_a,
  input  logic [8*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     done,
  output logic                 gt,
  output logic [PTR_W-1:0]     res_id,
  output logic                 busy
`ifdef COMP_GT8_RR_SCHED_STATS_EN
  ,
  output logic [15:0]          cmp_cnt,
  output logic [15:0]          gt_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int PAD_W = 1 << PTR_W;

  state_t               state_reg;
  logic [PTR_W-1:0]     ptr_reg;
  logic [PTR_W-1:0]     sel_reg;
  logic [PTR_W-1:0]     res_id_reg;
  logic [7:0]           op_a_reg;
  logic [7:0]           op_b_reg;
  logic [N_REQ-1:0]     gnt_reg;
  logic [N_REQ-1:0]     done_reg;
  logic                 gt_reg;
  logic                 busy_reg;

  logic [PTR_W-1:0]     win_next;
  logic                 win_vld_next;
  logic [N_REQ-1:0]     win_oh_next;
  logic [PAD_W-1:0]     req_pad;
  logic [7:0]           a_arr [N_REQ];
  logic [7:0]           b_arr [N_REQ];
  logic                 cmp_gt;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign a_arr[gi]       = req_a[8*gi +: 8];
      assign b_arr[gi]       = req_b[8*gi +: 8];
      assign win_oh_next[gi] = (win_next == PTR_W'(gi));
    end
  endgenerate

  // Scan from the highest offset down so the nearest set bit at/after ptr wins.
  always_comb begin
    logic [PTR_W:0] cand;
    req_pad              = '0;
    req_pad[N_REQ-1:0]   = req;
    win_next             = '0;
    win_vld_next         = 1'b0;
    cand                 = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, ptr_reg} + (PTR_W + 1)'(i);
      if (cand >= (PTR_W + 1)'(N_REQ))
        cand = cand - (PTR_W + 1)'(N_REQ);
      if (req_pad[cand[PTR_W-1:0]]) begin
        win_next     = cand[PTR_W-1:0];
        win_vld_next = 1'b1;
      end
    end
  end

  comp_gt8 u_cmp (
    .a  (op_a_reg),
    .b  (op_b_reg),
    .gt (cmp_gt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      ptr_reg    <= '0;
      sel_reg    <= '0;
      res_id_reg <= '0;
      op_a_reg   <= '0;
      op_b_reg   <= '0;
      gnt_reg    <= '0;
      done_reg   <= '0;
      gt_reg     <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (win_vld_next) begin
            op_a_reg  <= a_arr[win_next];
            op_b_reg  <= b_arr[win_next];
            sel_reg   <= win_next;
            gnt_reg   <= win_oh_next;
            busy_reg  <= 1'b1;
            state_reg <= CMP;
          end
        end
        CMP: begin
          gt_reg     <= cmp_gt;
          res_id_reg <= sel_reg;
          done_reg   <= gnt_reg;
          state_reg  <= RESP;
        end
        RESP: begin
          done_reg  <= '0;
          gnt_reg   <= '0;
          busy_reg  <= 1'b0;
          ptr_reg   <= (sel_reg == PTR_W'(N_REQ - 1)) ? '0 : sel_reg + 1'b1;
          state_reg <= IDLE;
        end
        default: begin
          done_reg  <= '0;
          gnt_reg   <= '0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign gnt    = gnt_reg;
  assign done   = done_reg;
  assign gt     = gt_reg;
  assign res_id = res_id_reg;
  assign busy   = busy_reg;

`ifdef COMP_GT8_RR_SCHED_STATS_EN
  logic [15:0] cmp_cnt_reg;
  logic [15:0] gt_cnt_reg;

  // gt_reg already holds the fresh result during RESP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmp_cnt_reg <= '0;
      gt_cnt_reg  <= '0;
    end else if (state_reg == RESP) begin
      if (cmp_cnt_reg != 16'hFFFF)
        cmp_cnt_reg <= cmp_cnt_reg + 16'd1;
      if (gt_reg && (gt_cnt_reg != 16'hFFFF))
        gt_cnt_reg <= gt_cnt_reg + 16'd1;
    end
  end

  assign cmp_cnt = cmp_cnt_reg;
  assign gt_cnt  = gt_cnt_reg;
`endif

endmodule
